rom_load_sequencer: RTL

//   Sequences ROM download from hps_io into the sprint2 core and owns core reset.
//   - Sits between hps_io ioctl_* and the sprint2 dn_* and Reset_n ports.
//   - Registers and forwards each download byte.
//   - Counts bytes against the expected image size and flags errors.
//   - Holds the core in reset during download, then for a fixed settle time after it.
//   - Applies the same settle time to OSD and user-button soft resets.

---
 rtl/rom_load_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: forwards hps_io ROM download bytes to the sprint2 core,
// validates the image size, and owns core reset (held through download plus
// a fixed settle time, also reused for OSD/button soft resets).
module rom_load_sequencer #(
  parameter logic [16:0] EXP_BYTES = 17'd65536,
  parameter logic [15:0] HOLD_CYC  = 16'd1024,
  parameter int          ADDR_W    = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              soft_rst,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_HOLD, S_RUN} state_t;

  // A zero hold time still needs one HOLD cycle, so the terminal count clamps at 0.
  localparam logic [15:0] HOLD_LAST = (HOLD_CYC == 16'd0) ? 16'd0 : HOLD_CYC - 16'd1;
  localparam logic [17:0] CNT_MAX   = '1;

  state_t      state, nxt;
  logic        wr_q;
  logic [17:0] byte_cnt;
  logic [15:0] hold_cnt;
  logic        drop_flag;

  logic wr_edge, accept, addr_oor, image_bad, load_entry;

  assign wr_edge    = ioctl_wr & ~wr_q;
  assign accept     = (state == S_LOAD) & wr_edge;
  assign addr_oor   = (ioctl_addr >> ADDR_W) != '0;
  // Counter saturates, so anything oversize can never alias back to EXP_BYTES.
  assign image_bad  = (byte_cnt != {1'b0, EXP_BYTES}) | drop_flag;
  assign load_entry = (nxt == S_LOAD) & (state != S_LOAD);

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state: a new download preempts everything, including soft reset
  always_comb begin
    nxt = state;
    if (ioctl_download) begin
      nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  nxt = S_IDLE;
        S_LOAD:  nxt = S_FLUSH;
        S_FLUSH: nxt = S_HOLD;
        S_HOLD:  if (!soft_rst && hold_cnt == HOLD_LAST) nxt = S_RUN;
        S_RUN:   if (soft_rst) nxt = S_HOLD;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Core reset: released only in RUN; soft reset pulls it low the same cycle
  always_comb begin
    core_reset_n = (state == S_RUN) & ~soft_rst;
  end

  // Byte path, byte/hold counters and load status
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      byte_cnt  <= '0;
      hold_cnt  <= '0;
      drop_flag <= 1'b0;
      dn_addr   <= '0;
      dn_data   <= '0;
      dn_wr     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wr_q  <= ioctl_wr;
      dn_wr <= 1'b0;
      if (load_entry) begin
        byte_cnt  <= '0;
        hold_cnt  <= '0;
        drop_flag <= 1'b0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
      if (accept) begin
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 18'd1;
        if (addr_oor) begin
          drop_flag <= 1'b1;
        end else begin
          dn_wr   <= 1'b1;
          dn_addr <= ioctl_addr[ADDR_W-1:0];
          dn_data <= ioctl_dout;
        end
      end
      case (state)
        S_FLUSH: begin
          hold_cnt <= '0;
          if (!ioctl_download) begin
            load_err  <= image_bad;
            load_done <= ~image_bad;
          end
        end
        S_HOLD: begin
          if (soft_rst)                   hold_cnt <= '0;
          else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 16'd1;
        end
        S_RUN:   hold_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
